// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: cell states, button index map
// and event id width.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  localparam int BTN_ID_W = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle between the raw button pins / consumer and the conditioner, plus per-cell
// debug state (2 bits per button, btn_state_e encoding).
interface button_conditioner_if
  import btn_pkg::*;
#(
  parameter int N_BTN = 5
);

  logic [N_BTN-1:0]    btn_raw;
  logic [N_BTN-1:0]    btn_level;
  logic [N_BTN-1:0]    btn_press;
  logic [N_BTN-1:0]    btn_release;
  logic                evt_valid;
  logic [BTN_ID_W-1:0] evt_id;
  logic [2*N_BTN-1:0]  dbg_state;

  // evt_valid is a one-cycle strobe with no ready: the sink must take evt_id in the
  // cycle evt_valid is high; evt_id reads 0 whenever evt_valid is low.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, evt_valid, evt_id, dbg_state
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, evt_valid, evt_id, dbg_state
  );

endinterface

// File: rtl/button_conditioner_debounce_cell.sv
// One button: 2-FF synchroniser, debounce FSM and counter, registered level/pulses.
// Optional auto-repeat of the press pulse while held, enabled by BTN_REPEAT_EN.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       press,
  output logic       rel,
  output logic [1:0] state
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE        = 2'(IDLE);
  localparam logic [1:0] ST_ARM_PRESS   = 2'(ARM_PRESS);
  localparam logic [1:0] ST_PRESSED     = 2'(PRESSED);
  localparam logic [1:0] ST_ARM_RELEASE = 2'(ARM_RELEASE);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             repeating;
  logic [RPT_W-1:0] rpt_last;

  // First repeat waits the long delay, later ones use the short period.
  assign rpt_last = repeating ? PERIOD_LAST : DELAY_LAST;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef BTN_REPEAT_EN
      rpt_cnt   <= '0;
      repeating <= 1'b0;
`endif
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef BTN_REPEAT_EN
      rpt_cnt   <= '0;
      repeating <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (s2) begin
            state <= ST_ARM_PRESS;
            cnt   <= '0;
          end
        end
        ST_ARM_PRESS: begin
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PRESSED;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!s2) begin
            state <= ST_ARM_RELEASE;
            cnt   <= '0;
          end
`ifdef BTN_REPEAT_EN
          else if (rpt_cnt == rpt_last) begin
            press     <= 1'b1;
            rpt_cnt   <= '0;
            repeating <= 1'b1;
          end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
            repeating <= repeating;
          end
`endif
        end
        ST_ARM_RELEASE: begin
          if (s2) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button receive path: one debounce_cell per button plus a lowest-index press
// event encoder. Auto-repeat is compiled in only when BTN_REPEAT_EN is defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 100000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  logic [N_BTN-1:0]    level;
  logic [N_BTN-1:0]    press;
  logic [N_BTN-1:0]    rel;
  logic [2*N_BTN-1:0]  dbg;
  logic                evt_hit;
  logic [BTN_ID_W-1:0] evt_next;
  logic                evt_valid_r;
  logic [BTN_ID_W-1:0] evt_id_r;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_raw[i]),
      .level(level[i]),
      .press(press[i]),
      .rel  (rel[i]),
      .state(dbg[2*i +: 2])
    );
  end

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    evt_hit  = 1'b0;
    evt_next = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) begin
        evt_hit  = 1'b1;
        evt_next = BTN_ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
    end else begin
      evt_valid_r <= evt_hit;
      evt_id_r    <= evt_next;
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.evt_valid   = evt_valid_r;
  assign bus.evt_id      = evt_id_r;
  assign bus.dbg_state   = dbg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timing sequences, a segment table and random
// stimulus, all scored per cycle against a window-based reference model.
module tb_button_conditioner;

  localparam int N     = 5;
  localparam int D     = 8;
  localparam int RD    = 16;
  localparam int RP    = 4;
  localparam int W     = 19;
  localparam int LOG_N = 8192;

  logic clk;
  logic rst;

  button_conditioner_if #(.N_BTN(N)) bif ();

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
`ifdef BTN_REPEAT_EN
    ,
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] log_v[0:LOG_N-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Level flips once the last D+1 synchronised samples all disagree with it; the
  // synchroniser is a 2-sample delay line that reset refills with zeros.
  logic [N-1:0] dly_q[$];
  logic [N-1:0] win_q[$];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  int           hp[N];

  always @(posedge clk) begin
    logic [N-1:0] seen, nl, np, nr;
    logic         nv, all_hi, all_lo;
    logic [2:0]   nid;
    cyc++;
    nv  = 1'b0;
    nid = 3'd0;
    for (int b = 0; b < N; b++) begin
      if (m_press[b] && !nv) begin
        nv  = 1'b1;
        nid = 3'(b);
      end
    end
    np = '0;
    nr = '0;
    nl = m_level;
    if (rst) begin
      dly_q = '{5'd0, 5'd0};
      win_q.delete();
      nl  = '0;
      nv  = 1'b0;
      nid = 3'd0;
      for (int b = 0; b < N; b++) hp[b] = -1;
    end else begin
      dly_q.push_back(bif.btn_raw);
      seen = dly_q.pop_front();
      win_q.push_back(seen);
      if (win_q.size() > D + 1) void'(win_q.pop_front());
      for (int b = 0; b < N; b++) begin
        all_hi = (win_q.size() == D + 1);
        all_lo = all_hi;
        foreach (win_q[k]) begin
          all_hi &= win_q[k][b];
          all_lo &= !win_q[k][b];
        end
        if (!m_level[b] && all_hi) begin
          nl[b] = 1'b1;
          np[b] = 1'b1;
          hp[b] = 0;
        end else if (m_level[b] && all_lo) begin
          nl[b] = 1'b0;
          nr[b] = 1'b1;
          hp[b] = -1;
        end else if (m_level[b]) begin
          if (!seen[b]) hp[b] = -1;
          else if (hp[b] < 0) hp[b] = 0;
          else begin
            hp[b]++;
`ifdef BTN_REPEAT_EN
            if (hp[b] >= RD && (hp[b] - RD) % RP == 0) np[b] = 1'b1;
`endif
          end
        end
      end
    end
    m_level = nl;
    m_press = np;
    exp_q.push_back({nl, np, nr, nv, nid});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    act = {bif.btn_level, bif.btn_press, bif.btn_release, bif.evt_valid, bif.evt_id};
    if (cyc < LOG_N) log_v[cyc] = act;
    if (exp_q.size() > 0) check($sformatf("scoreboard@%0d", cyc), 32'(act), 32'(exp_q.pop_front()));
    else begin
      failures++;
      $display("FAIL scoreboard_empty cycle=%0d actual=%h", cyc, act);
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the negedge following edge e; the next edge is e+1.
  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [N-1:0] raw;
    int           hold;
    logic [N-1:0] exp_level;
    int           exp_press;
    int           exp_rel;
  } row_t;

  row_t         tbl[11];
  int           e0, e1, e2, f, e3, p, s, np_cnt, nr_cnt;
  logic [W-1:0] acc;
  logic         any, e_bit;

  initial begin
    tbl[0]  = '{5'b00010,  5, 5'b00000, 0, 0};
    tbl[1]  = '{5'b00000,  1, 5'b00000, 0, 0};
    tbl[2]  = '{5'b00010,  5, 5'b00000, 0, 0};
    tbl[3]  = '{5'b00000, 20, 5'b00000, 0, 0};
    tbl[4]  = '{5'b10100, 20, 5'b10100, 2, 0};
    tbl[5]  = '{5'b00000, 20, 5'b00000, 0, 2};
    tbl[6]  = '{5'b00001, 20, 5'b00001, 1, 0};
    tbl[7]  = '{5'b00011, 20, 5'b00011, 1, 0};
    tbl[8]  = '{5'b00001,  7, 5'b00011, 0, 0};
    tbl[9]  = '{5'b00011, 20, 5'b00011, 0, 0};
    tbl[10] = '{5'b00000, 20, 5'b00000, 0, 2};

    rst = 1'b1;
    bif.btn_raw = '0;
    wait_edge(4);
    rst = 1'b0;

    // Reset and idle: every output stays 0.
    wait_edge(104);
    check("reset_state", 32'(log_v[1]), 32'd0);
    acc = '0;
    for (int e = 1; e <= 104; e++) acc |= log_v[e];
    check("idle_outputs", 32'(acc), 32'd0);

    // Single press: pulse and level at E0+10, event at E0+11.
    bif.btn_raw = 5'b00001;
    e0 = cyc + 1;
    wait_edge(e0 + 11);
    check("press0_before", 32'(log_v[e0 + 9][9]), 32'd0);
    check("level0_before", 32'(log_v[e0 + 9][14]), 32'd0);
    check("press0_edge", 32'(log_v[e0 + 10][13:9]), 32'b00001);
    check("level0_edge", 32'(log_v[e0 + 10][18:14]), 32'b00001);
    check("evt_press0", 32'(log_v[e0 + 11][3:0]), 32'b1000);
    check("press0_single", 32'(log_v[e0 + 11][9]), 32'd0);

    // Release after a 30-cycle hold: release pulse at E1+10, no event.
    wait_edge(e0 + 29);
    bif.btn_raw = 5'b00000;
    e1 = cyc + 1;
    wait_edge(e1 + 11);
    check("release0_before", 32'(log_v[e1 + 9][4]), 32'd0);
    check("release0_edge", 32'(log_v[e1 + 10][8:4]), 32'b00001);
    check("level0_released", 32'(log_v[e1 + 10][14]), 32'd0);
    check("evt_after_release", 32'(log_v[e1 + 11][3:0]), 32'd0);

    // Reset mid-debounce with bit3 held: progress discarded, press 10 edges after.
    wait_edge(e1 + 20);
    bif.btn_raw = 5'b01000;
    e2 = cyc + 1;
    wait_edge(e2 + 7);
    rst = 1'b1;
    wait_edge(e2 + 9);
    rst = 1'b0;
    f = e2 + 10;
    wait_edge(f + 11);
    any = 1'b0;
    for (int e = e2; e <= f + 9; e++) any |= log_v[e][12];
    check("rst_no_early_press", 32'(any), 32'd0);
    check("rst_press3_edge", 32'(log_v[f + 10][13:9]), 32'b01000);
    check("rst_level3_edge", 32'(log_v[f + 10][17]), 32'd1);
    bif.btn_raw = 5'b00000;
    wait_edge(cyc + 20);

    // Simultaneous presses of bits 2 and 4: one event, lowest index.
    bif.btn_raw = 5'b10100;
    e3 = cyc + 1;
    p  = e3 + 10;
    wait_edge(p + 2);
    check("dual_press_edge", 32'(log_v[p][13:9]), 32'b10100);
    check("dual_evt", 32'(log_v[p + 1][3:0]), 32'b1010);
    check("dual_no_second_evt", 32'(log_v[p + 2][3:0]), 32'd0);

    // Hold bit4 for 40 cycles after its press: auto-repeat only with the macro.
    wait_edge(p + 40);
    for (int k = 0; k <= 40; k++) begin
      e_bit = (k == 0);
`ifdef BTN_REPEAT_EN
      if (k >= RD && (k - RD) % RP == 0) e_bit = 1'b1;
`endif
      check($sformatf("hold_press4_k%0d", k), 32'(log_v[p + k][13]), 32'(e_bit));
    end
    bif.btn_raw = 5'b00000;
    wait_edge(cyc + 20);

    // Segment table: glitches, overlapping holds, release bounces.
    for (int r = 0; r < 11; r++) begin
      s = cyc + 1;
      bif.btn_raw = tbl[r].raw;
      wait_edge(s + tbl[r].hold - 1);
      np_cnt = 0;
      nr_cnt = 0;
      for (int e = s; e < s + tbl[r].hold; e++) begin
        for (int b = 0; b < N; b++) begin
          if (log_v[e][9 + b] && !log_v[e - 1][14 + b]) np_cnt++;
          if (log_v[e][4 + b] && log_v[e - 1][14 + b]) nr_cnt++;
        end
      end
      check($sformatf("row%0d_level", r), 32'(log_v[s + tbl[r].hold - 1][18:14]), 32'(tbl[r].exp_level));
      check($sformatf("row%0d_press", r), 32'(np_cnt), 32'(tbl[r].exp_press));
      check($sformatf("row%0d_release", r), 32'(nr_cnt), 32'(tbl[r].exp_rel));
    end

    // Random segments with occasional resets; the scoreboard checks every cycle.
    for (int seg = 0; seg < 220; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        wait_edge(cyc + $urandom_range(1, 3));
        rst = 1'b0;
      end
      bif.btn_raw = 5'($urandom);
      wait_edge(cyc + $urandom_range(1, 24));
    end

    bif.btn_raw = '0;
    wait_edge(cyc + 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
